// File: rtl/pwm_pkg.sv
// pwm_pkg: sine fraction table, sequencer state encoding, duty and step-length helpers
package pwm_pkg;
  localparam int NSTEPS = 36;
  localparam int FULL = 10000;
  localparam int SINE_FRAC [0:NSTEPS-1] = '{
    5000, 5893, 6757, 7564, 8290, 8909, 9403, 9755, FULL, FULL, FULL, 9598,
    9173, 8614, 7939, 7169, 6330, 5448, 4552, 3670, 2831, 2061, 1386, 827,
    402, 125, 5, 45, 245, 597, 1091, 1710, 2436, 3243, 4107, 5000
  };
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  function automatic int duty_of(input int idx, input int r);
    return SINE_FRAC[idx] >= FULL ? (1 << r) - 1 : ((1 << r) * SINE_FRAC[idx]) / 10000;
  endfunction
  function automatic logic [11:0] n_of(input logic [3:0] sel, input int base, input int step);
    return 12'(base + step * int'(sel));
  endfunction
endpackage

// File: rtl/wrap_step_counter.sv
// wrap_step_counter: counts pwm_wrap pulses (i_en/i_wrap) against a limit loaded on i_load, o_bnd marks the last wrap of a step
module wrap_step_counter #(
  parameter logic [11:0] RST_LIM = 12'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_wrap,
  input  logic        i_load,
  input  logic [11:0] i_lim,
  output logic        o_bnd
);
  logic [11:0] r_cnt;
  logic [11:0] r_lim;
  assign o_bnd = i_en && i_wrap && r_cnt == r_lim - 12'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_lim <= RST_LIM;
    end else if (i_load) begin
      r_cnt <= '0;
      r_lim <= i_lim;
    end else if (i_en && i_wrap) begin
      r_cnt <= r_cnt + 12'd1;
    end
  end
endmodule

// File: rtl/sine_duty_seq.sv
// sine_duty_seq: steps a 36-entry sine duty table every N pwm_wrap pulses (in: enable, period_sel, pwm_wrap; out: duty, duty_valid, step_idx, cycle_done, busy)
module sine_duty_seq
  import pwm_pkg::*;
#(
  parameter int R = 6,
  parameter int CNT_BASE = 1000,
  parameter int CNT_STEP = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [3:0]   period_sel,
  input  logic         pwm_wrap,
  output logic [R-1:0] duty,
  output logic         duty_valid,
  output logic [5:0]   step_idx,
  output logic         cycle_done,
  output logic         busy
);
  localparam logic [R-1:0] MID = R'(1 << (R - 1));
  if (CNT_BASE + 15 * CNT_STEP > 4095) begin : g_bad_cnt
    $error("sine_duty_seq: CNT_BASE + 15*CNT_STEP exceeds 12-bit wrap counter");
  end
  logic [R-1:0] w_tab [0:NSTEPS-1];
  for (genvar i = 0; i < NSTEPS; i++) begin : g_tab
    assign w_tab[i] = R'(duty_of(i, R));
  end
  logic [1:0] r_state;
  logic [5:0] w_nxt;
  logic       w_last;
  logic       w_start;
  logic       w_bnd;
  logic       w_end;
  assign busy = r_state != S_IDLE;
  assign w_last = step_idx == 6'(NSTEPS - 1);
  assign w_nxt = w_last ? '0 : step_idx + 6'd1;
  assign w_start = r_state == S_IDLE && enable;
  assign w_end = r_state == S_DRAIN && !enable && w_bnd && w_last;
  wrap_step_counter #(
    .RST_LIM(n_of(4'd0, CNT_BASE, CNT_STEP))
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (busy),
    .i_wrap(pwm_wrap),
    .i_load(w_start || w_bnd),
    .i_lim (n_of(period_sel, CNT_BASE, CNT_STEP)),
    .o_bnd (w_bnd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      duty <= MID;
      duty_valid <= 1'b0;
      step_idx <= '0;
      cycle_done <= 1'b0;
    end else begin
      duty_valid <= w_start || w_bnd;
      cycle_done <= w_bnd && w_last;
      if (w_start) begin
        r_state <= S_RUN;
        step_idx <= '0;
        duty <= w_tab[0];
      end else if (busy) begin
        r_state <= enable ? S_RUN : w_end ? S_IDLE : S_DRAIN;
        if (w_bnd) begin
          step_idx <= w_nxt;
          duty <= w_end ? MID : w_tab[w_nxt];
        end
      end
    end
  end
endmodule

// File: tb/tb_sine_duty_seq.sv
// tb_sine_duty_seq: scoreboard bench for sine_duty_seq with R=6, CNT_BASE=2, CNT_STEP=1
module tb_sine_duty_seq;
  import pwm_pkg::*;
  localparam int EXP_DUTY [0:35] = '{
    32, 37, 43, 48, 53, 57, 60, 62, 63, 63, 63, 61, 58, 55, 50, 45, 40, 34,
    29, 23, 18, 13, 8, 5, 2, 0, 0, 0, 1, 3, 6, 10, 15, 20, 26, 32
  };
  typedef struct packed {
    logic [5:0] duty;
    logic [5:0] idx;
    logic       done;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] period_sel = 4'd0;
  logic       pwm_wrap = 1'b0;
  logic [5:0] duty;
  logic       duty_valid;
  logic [5:0] step_idx;
  logic       cycle_done;
  logic       busy;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_idx = 0;
  int   m_cnt = 0;
  int   m_n = 2;
  bit   m_active = 0;
  bit   m_drain = 0;
  bit   prev_valid = 0;
  always #5 clk = ~clk;
  sine_duty_seq #(.R(6), .CNT_BASE(2), .CNT_STEP(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .period_sel(period_sel),
    .pwm_wrap  (pwm_wrap),
    .duty      (duty),
    .duty_valid(duty_valid),
    .step_idx  (step_idx),
    .cycle_done(cycle_done),
    .busy      (busy)
  );
  task automatic push(input int d, input int i, input bit dn);
    exp_t e;
    e = '{duty: 6'(d), idx: 6'(i), done: dn};
    sb.push_back(e);
  endtask
  task automatic cyc(input logic w);
    exp_t e;
    bit wrapped;
    pwm_wrap = w;
    if (rst) begin
      m_active = 0; m_drain = 0; m_idx = 0; m_cnt = 0; m_n = 2;
      sb.delete();
    end else if (!m_active) begin
      if (enable) begin
        m_active = 1; m_drain = 0; m_idx = 0; m_cnt = 0; m_n = 2 + int'(period_sel);
        push(EXP_DUTY[0], 0, 0);
      end
    end else begin
      if (w) begin
        if (m_cnt == m_n - 1) begin
          wrapped = m_idx == 35;
          m_idx = wrapped ? 0 : m_idx + 1;
          m_cnt = 0;
          m_n = 2 + int'(period_sel);
          if (m_drain && !enable && wrapped) begin
            m_active = 0;
            push(32, 0, 1);
          end else push(EXP_DUTY[m_idx], m_idx, wrapped);
        end else m_cnt++;
      end
      if (m_active) m_drain = !enable;
    end
    @(posedge clk);
    #1;
    pwm_wrap = 1'b0;
    n_cmp++;
    if (busy !== m_active) begin
      n_bad++; $display("FAIL busy: got %0b want %0b", busy, m_active);
    end
    n_cmp++;
    if (duty_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_bad++; $display("FAIL sb_unexpected: duty_valid high with duty=%0d idx=%0d, want no update", duty, step_idx);
      end else begin
        e = sb.pop_front();
        if ({duty, step_idx, cycle_done} !== e) begin
          n_bad++;
          $display("FAIL sb_update: got duty=%0d idx=%0d done=%0b, want duty=%0d idx=%0d done=%0b",
                   duty, step_idx, cycle_done, e.duty, e.idx, e.done);
        end
      end
      n_cmp++;
      if (prev_valid) begin
        n_bad++; $display("FAIL valid_double: got duty_valid high two cycles, want single pulse");
      end
    end else if (sb.size() != 0 || cycle_done !== 1'b0 || duty_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_missing: got valid=%0b done=%0b, want valid=1 (pending %0d)", duty_valid, cycle_done, sb.size());
      sb.delete();
    end
    prev_valid = duty_valid === 1'b1;
  endtask
  task automatic wrap4();
    cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
  endtask
  task automatic run_to(input int t);
    int k = 0;
    while (step_idx !== 6'(t) && k < 300) begin
      wrap4();
      k++;
    end
    n_cmp++;
    if (step_idx !== 6'(t)) begin
      n_bad++; $display("FAIL run_to_timeout: got idx=%0d want %0d", step_idx, t);
    end
  endtask
  task automatic drain_to_idle();
    int k = 0;
    while (busy === 1'b1 && k < 300) begin
      wrap4();
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL drain_timeout: got busy=%0b want 0", busy);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (3) cyc(1'b0);
    n_cmp++; if (duty !== 6'd32) begin n_bad++; $display("FAIL reset_duty: got %0d want 32", duty); end
    n_cmp++; if (step_idx !== 6'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", step_idx); end
    n_cmp++; if (u_dut.u_cnt.r_cnt !== 12'd0) begin n_bad++; $display("FAIL reset_wrap_cnt: got %0d want 0", u_dut.u_cnt.r_cnt); end
    rst = 1'b0;
    repeat (3) wrap4();
    n_cmp++; if (duty !== 6'd32) begin n_bad++; $display("FAIL idle_duty: got %0d want 32", duty); end
    n_cmp++; if (u_dut.u_cnt.r_cnt !== 12'd0) begin n_bad++; $display("FAIL idle_wrap_ignored: got %0d want 0", u_dut.u_cnt.r_cnt); end
  endtask
  task automatic test_table();
    period_sel = 4'd0; enable = 1'b1;
    cyc(1'b0);
    n_cmp++; if (duty_valid !== 1'b1 || duty !== 6'd32) begin n_bad++; $display("FAIL start: got valid=%0b duty=%0d want 1/32", duty_valid, duty); end
    repeat (2) wrap4();
    n_cmp++; if (duty !== 6'd37) begin n_bad++; $display("FAIL duty_2wraps: got %0d want 37", duty); end
    repeat (2) wrap4();
    n_cmp++; if (duty !== 6'd43) begin n_bad++; $display("FAIL duty_4wraps: got %0d want 43", duty); end
    run_to(8);
    n_cmp++; if (duty !== 6'd63) begin n_bad++; $display("FAIL duty_idx8: got %0d want 63", duty); end
    run_to(10);
    n_cmp++; if (duty !== 6'd63) begin n_bad++; $display("FAIL duty_idx10: got %0d want 63", duty); end
    run_to(24);
    n_cmp++; if (duty !== 6'd2) begin n_bad++; $display("FAIL duty_idx24: got %0d want 2", duty); end
    run_to(26);
    n_cmp++; if (duty !== 6'd0) begin n_bad++; $display("FAIL duty_idx26: got %0d want 0", duty); end
  endtask
  task automatic test_period_change();
    cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    period_sel = 4'd3;
    wrap4();
    n_cmp++; if (step_idx !== 6'd27) begin n_bad++; $display("FAIL sel_mid_step: got idx=%0d want 27", step_idx); end
    repeat (4) wrap4();
    n_cmp++; if (step_idx !== 6'd27) begin n_bad++; $display("FAIL sel_4of5: got idx=%0d want 27", step_idx); end
    wrap4();
    n_cmp++; if (step_idx !== 6'd28) begin n_bad++; $display("FAIL sel_5of5: got idx=%0d want 28", step_idx); end
    period_sel = 4'd0;
    repeat (5) wrap4();
    n_cmp++; if (step_idx !== 6'd29) begin n_bad++; $display("FAIL sel_latched: got idx=%0d want 29", step_idx); end
  endtask
  task automatic test_full_cycle();
    int dones = 0;
    run_to(35);
    for (int k = 0; k < 8; k++) begin
      cyc(k % 4 == 0);
      dones += int'(cycle_done);
    end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL cycle_done_count: got %0d want 1", dones); end
    n_cmp++; if (step_idx !== 6'd0 || duty !== 6'd32 || busy !== 1'b1) begin n_bad++; $display("FAIL wrap_state: got idx=%0d duty=%0d busy=%0b want 0/32/1", step_idx, duty, busy); end
  endtask
  task automatic test_drain();
    rst = 1'b1; enable = 1'b0; cyc(1'b0); rst = 1'b0;
    enable = 1'b1; cyc(1'b0);
    run_to(5);
    enable = 1'b0;
    repeat (4) wrap4();
    n_cmp++; if (busy !== 1'b1 || step_idx !== 6'd7) begin n_bad++; $display("FAIL drain_continues: got busy=%0b idx=%0d want 1/7", busy, step_idx); end
    drain_to_idle();
    n_cmp++; if (u_dut.r_state !== S_IDLE || duty !== 6'd32 || step_idx !== 6'd0) begin n_bad++; $display("FAIL drain_end: got state=%0d duty=%0d idx=%0d want 0/32/0", u_dut.r_state, duty, step_idx); end
    repeat (2) wrap4();
    n_cmp++; if (duty !== 6'd32 || busy !== 1'b0) begin n_bad++; $display("FAIL drain_idle_hold: got duty=%0d busy=%0b want 32/0", duty, busy); end
  endtask
  task automatic test_drain_from_start();
    enable = 1'b1; cyc(1'b0); enable = 1'b0;
    repeat (4) wrap4();
    n_cmp++; if (busy !== 1'b1 || step_idx !== 6'd2) begin n_bad++; $display("FAIL start_drain: got busy=%0b idx=%0d want 1/2", busy, step_idx); end
    drain_to_idle();
    n_cmp++; if (step_idx !== 6'd0 || duty !== 6'd32) begin n_bad++; $display("FAIL start_drain_end: got idx=%0d duty=%0d want 0/32", step_idx, duty); end
  endtask
  task automatic test_drain_resume();
    enable = 1'b1; cyc(1'b0);
    run_to(5);
    enable = 1'b0;
    run_to(20);
    enable = 1'b1;
    run_to(22);
    n_cmp++; if (busy !== 1'b1 || duty !== 6'd8) begin n_bad++; $display("FAIL resume: got busy=%0b duty=%0d want 1/8", busy, duty); end
    run_to(35);
    repeat (2) wrap4();
    n_cmp++; if (busy !== 1'b1 || step_idx !== 6'd0 || u_dut.r_state !== S_RUN) begin n_bad++; $display("FAIL resume_wrap: got busy=%0b idx=%0d state=%0d want 1/0/1", busy, step_idx, u_dut.r_state); end
  endtask
  task automatic test_reset_mid();
    run_to(17);
    cyc(1'b1);
    rst = 1'b1; enable = 1'b0;
    cyc(1'b0);
    n_cmp++; if (duty !== 6'd32 || step_idx !== 6'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid: got duty=%0d idx=%0d busy=%0b want 32/0/0", duty, step_idx, busy); end
    n_cmp++; if (u_dut.u_cnt.r_cnt !== 12'd0) begin n_bad++; $display("FAIL rst_mid_wrap_cnt: got %0d want 0", u_dut.u_cnt.r_cnt); end
    rst = 1'b0;
    repeat (2) wrap4();
  endtask
  initial begin
    test_reset();
    test_table();
    test_period_change();
    test_full_cycle();
    test_drain();
    test_drain_from_start();
    test_drain_resume();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sine_duty_seq.md
Name: sine_duty_seq

Overview:
Upstream sequencer for the basic PWM stage. It walks a 36-entry sine duty table and holds each duty word for N PWM periods. N is chosen by a 4-bit speed selector. It emits duty[R-1:0] plus a one-cycle update strobe, and the PWM comparator consumes duty directly. It counts the PWM counter wrap pulse, so duty changes only on PWM period boundaries.

Parameters:
R, 6, PWM counter / duty width in bits; full scale is 2^R-1.
CNT_BASE, 1000, PWM periods per step at period_sel=0.
CNT_STEP, 200, extra PWM periods per period_sel increment; N = CNT_BASE + CNT_STEP*period_sel (default range 1000..4000).
NSTEPS, 36, table length; fixed, not overridable.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
enable  in  1  level; 1 = run the sine sequence.
period_sel  in  4  speed selector; sampled only at step boundaries and at start.
pwm_wrap  in  1  one-cycle pulse from the PWM stage when its counter equals 2^R-1.
duty  out  R  duty word to the PWM comparator.
duty_valid  out  1  one-cycle strobe, high the cycle duty takes a new value.
step_idx  out  6  current table index, 0..35.
cycle_done  out  1  one-cycle pulse when the index wraps 35->0.
busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset values: duty = 2^(R-1) (midscale), duty_valid = 0, step_idx = 0, cycle_done = 0, busy = 0, wrap_cnt = 0, state = IDLE, n_lat = N(0).
- Reset asserted mid-operation returns everything to the reset values on the next edge, with no drain.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN when enable = 1.
  - On that edge: n_lat <= N(period_sel), wrap_cnt <= 0, step_idx <= 0, duty <= TABLE[0], duty_valid <= 1.
- RUN: each pwm_wrap increments wrap_cnt.
- Step boundary: pwm_wrap = 1 with wrap_cnt == n_lat-1. Next edge:
  - wrap_cnt <= 0.
  - step_idx <= step_idx+1, wrapping 35 -> 0.
  - duty <= TABLE[new idx], duty_valid <= 1.
  - n_lat <= N(period_sel).
  - cycle_done <= 1 if idx wrapped.
- Latency: duty updates 1 clk after the boundary wrap pulse. It is therefore stable for the whole next PWM period.
- RUN -> DRAIN when enable = 0. In DRAIN the sequence keeps stepping normally until idx wraps 35 -> 0.
  - On that boundary: go to IDLE, duty <= midscale, duty_valid <= 1, cycle_done <= 1.
- DRAIN -> RUN if enable returns to 1 before the wrap; the sequence continues without a restart.
- Enable falling while idx == 0 and wrap_cnt == 0 (just started) still drains a full cycle.
- pwm_wrap is ignored in IDLE.
- pwm_wrap high on consecutive clocks is counted once per clock.
- period_sel changes mid-step have no effect until the next boundary.
- Arithmetic:
  - wrap_cnt is 12 bits.
  - N is computed in 12-bit unsigned with no overflow for the defaults. Parameter sets where CNT_BASE+15*CNT_STEP > 4095 are illegal; flag them with an elaboration check.
- Table: duty = floor(2^R * f / 10000), where f in index order is: 5000, 5893, 6757, 7564, 8290, 8909, 9403, 9755, FULL, FULL, FULL, 9598, 9173, 8614, 7939, 7169, 6330, 5448, 4552, 3670, 2831, 2061, 1386, 827, 402, 125, 5, 45, 245, 597, 1091, 1710, 2436, 3243, 4107, 5000.
  - FULL = 2^R-1 exactly.
  - All values are computed at elaboration with integer math only; no real arithmetic in synthesized logic.
- duty_valid and cycle_done are never high for more than one consecutive cycle.

Decomposition:
- Shared package pwm_pkg holds:
  - SINE_FRAC[0:35] (x10000 constants above).
  - NSTEPS = 36.
  - State encoding for IDLE/RUN/DRAIN.
  - Function duty_of(idx, R) returning the truncated duty word.
  - Function n_of(sel, base, step).
- One natural sub-module: wrap_step_counter. It counts pwm_wrap up to a loaded limit and outputs a boundary pulse. The FSM, index and table lookup stay in sine_duty_seq.

Test Plan:
- Use R=6, CNT_BASE=2, CNT_STEP=1 unless noted.
- rst held 3 clks, then released with enable=0 -> duty=32, busy=0, step_idx=0; pwm_wrap pulses are ignored.
- enable=1, period_sel=0, pwm_wrap every 4 clks -> duty=32 with valid on the first edge. After 2 wraps duty=37; after 4 wraps duty=43. Indices 8..10 give 63, index 26 gives 0, index 24 gives 2.
- period_sel 0 -> 3 mid-step -> the current step still lasts 2 wraps; every following step lasts 5 wraps.
- Full run to idx 35 -> 0 -> cycle_done pulses exactly once, step_idx=0, duty=32, valid asserted.
- enable dropped at idx 5 -> steps continue through 35; at the wrap state=IDLE, duty=32, busy=0. Re-raising enable at idx 20 instead continues from 20 with no restart.
- rst asserted at idx 17 mid-step -> next clk: duty=32, step_idx=0, busy=0, wrap_cnt=0.
